// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: reset level, data/PC widths,
// stall vector layout, multi-cycle FSM state encodings and a length helper.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b1;

  localparam int PcWidth = 32;
  localparam logic [PcWidth-1:0] ZeroWord = '0;

  // Stall vector: one bit per pipeline register, PC first, WB last.
  localparam int StallWidth  = 6;
  localparam int StallPcBit  = 0;
  localparam int StallIfBit  = 1;
  localparam int StallIdBit  = 2;
  localparam int StallExBit  = 3;
  localparam int StallMemBit = 4;
  localparam int StallWbBit  = 5;

  localparam logic [StallWidth-1:0] StallNone = '0;
  // Freeze everything up to and including ID (load-use bubble into EX).
  localparam logic [StallWidth-1:0] StallToId =
    StallWidth'((1 << StallPcBit) | (1 << StallIfBit) | (1 << StallIdBit));
  // Freeze everything up to and including EX (EX busy or externally held).
  localparam logic [StallWidth-1:0] StallToEx =
    StallWidth'((1 << StallPcBit) | (1 << StallIfBit) | (1 << StallIdBit) | (1 << StallExBit));
  // MEM and WB never stall; they keep draining so older work retires.
  localparam logic [StallWidth-1:0] StallDrainMask =
    StallWidth'((1 << StallMemBit) | (1 << StallWbBit));

  // Multi-cycle sequencer.
  localparam int McLenWidth = 6;
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

  // Statistics counter.
  localparam int StatWidth = 32;
  localparam logic [StatWidth-1:0] StatMax = '1;

  // Counter preload: a length of 0 behaves like 1, so BUSY lasts max(len,1) cycles.
  function automatic logic [McLenWidth-1:0] mc_load(input logic [McLenWidth-1:0] len);
    return (len == '0) ? '0 : len - McLenWidth'(1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Multi-cycle operation sequencer: IDLE -> BUSY (down-counter) -> DONE -> IDLE.
// abort returns to IDLE from any state on the next edge, suppressing DONE.
module mc_seq
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [McLenWidth-1:0] len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state_q, state_d;
  logic [McLenWidth-1:0] cnt_q, cnt_d;

  // Next-state and counter update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MC_IDLE: begin
        if (req && !abort) begin
          state_d = MC_BUSY;
          cnt_d   = mc_load(len);
        end
      end
      MC_BUSY: begin
        if (abort) begin
          state_d = MC_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = MC_DONE;
        end else begin
          cnt_d = cnt_q - McLenWidth'(1);
        end
      end
      MC_DONE: begin
        // A request arriving while the result is presented is dropped.
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MC_BUSY);
  assign done = (state_q == MC_DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: combinational stall/flush generation, multi-cycle
// sequencer instance and a saturating count of stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_ex_i,
  input  logic                  mc_req_i,
  input  logic [McLenWidth-1:0] mc_len_i,
  input  logic                  flush_req_i,
  input  logic [PcWidth-1:0]    flush_pc_i,
  output logic [StallWidth-1:0] stall_o,
  output logic                  flush_o,
  output logic [PcWidth-1:0]    new_pc_o,
  output logic                  mc_busy_o,
  output logic                  mc_done_o,
  output logic [StatWidth-1:0]  stall_cycles_o
);

  logic                 mc_busy;
  logic                 mc_done;
  logic [StallWidth-1:0] stall_d;
  logic [StatWidth-1:0]  stall_cycles_q, stall_cycles_d;

  mc_seq u_mc_seq (
    .clk   (clk),
    .rst   (rst),
    .req   (mc_req_i),
    .len   (mc_len_i),
    .abort (flush_req_i),
    .busy  (mc_busy),
    .done  (mc_done)
  );

  // Stall/flush priority: reset, then flush, then EX hold, then ID hazard.
  always_comb begin
    stall_d = StallNone;
    if (rst == RstEnable || flush_req_i) begin
      stall_d = StallNone;
    end else if (mc_busy || stallreq_ex_i) begin
      stall_d = StallToEx;
    end else if (stallreq_id_i) begin
      stall_d = StallToId;
    end
  end

  assign stall_o   = stall_d & ~StallDrainMask;
  assign flush_o   = (rst != RstEnable) && flush_req_i;
  assign new_pc_o  = flush_o ? flush_pc_i : ZeroWord;
  assign mc_busy_o = mc_busy;
  assign mc_done_o = mc_done;

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o != StallNone && stall_cycles_q != StatMax) begin
      stall_cycles_d = stall_cycles_q + StatWidth'(1);
    end
  end

  // Statistics register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expectations are queued when the
// stimulus is driven and popped when the outputs are sampled.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id_i = 1'b0;
  logic        stallreq_ex_i = 1'b0;
  logic        mc_req_i = 1'b0;
  logic [5:0]  mc_len_i = 6'd0;
  logic        flush_req_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_done_o;
  logic [31:0] stall_cycles_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] cnt_exp = 32'h0;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .mc_req_i       (mc_req_i),
    .mc_len_i       (mc_len_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .mc_busy_o      (mc_busy_o),
    .mc_done_o      (mc_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, queue the expected
  // outputs, sample 2 time units later, then advance the counter model.
  task automatic step(input string tag, input logic id, input logic ex,
                      input logic req, input logic [5:0] len,
                      input logic fl, input logic [31:0] pc,
                      input logic [5:0] e_stall, input logic e_busy, input logic e_done);
    exp_t e;
    exp_t got;
    @(negedge clk);
    check32({tag, ".stall_cycles"}, stall_cycles_o, cnt_exp);
    stallreq_id_i = id;
    stallreq_ex_i = ex;
    mc_req_i      = req;
    mc_len_i      = len;
    flush_req_i   = fl;
    flush_pc_i    = pc;
    e.stall  = e_stall;
    e.flush  = fl;
    e.new_pc = fl ? pc : 32'h0;
    e.busy   = e_busy;
    e.done   = e_done;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      check32({tag, ".stall"},  32'(stall_o),   32'(got.stall));
      check32({tag, ".flush"},  32'(flush_o),   32'(got.flush));
      check32({tag, ".new_pc"}, new_pc_o,       got.new_pc);
      check32({tag, ".busy"},   32'(mc_busy_o), 32'(got.busy));
      check32({tag, ".done"},   32'(mc_done_o), 32'(got.done));
    end
    if (e_stall != 6'b0 && cnt_exp != 32'hFFFF_FFFF) cnt_exp = cnt_exp + 32'd1;
  endtask

  initial begin
    // Reset held with noisy inputs: everything must read zero.
    stallreq_id_i = 1'b1;
    stallreq_ex_i = 1'b1;
    flush_req_i   = 1'b1;
    flush_pc_i    = 32'hDEAD_BEEF;
    mc_req_i      = 1'b1;
    #1;
    check32("rst.stall",        32'(stall_o),   32'h0);
    check32("rst.flush",        32'(flush_o),   32'h0);
    check32("rst.new_pc",       new_pc_o,       32'h0);
    check32("rst.busy",         32'(mc_busy_o), 32'h0);
    check32("rst.done",         32'(mc_done_o), 32'h0);
    check32("rst.stall_cycles", stall_cycles_o, 32'h0);
    @(posedge clk);
    #1;
    check32("rst_edge.busy", 32'(mc_busy_o), 32'h0);
    @(negedge clk);
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b0;
    flush_req_i   = 1'b0;
    flush_pc_i    = 32'h0;
    mc_req_i      = 1'b0;
    rst = 1'b0;

    // len=4 accepted on the first edge after reset: 4 BUSY cycles then DONE.
    step("len4_req",  0, 0, 1, 6'd4, 0, 32'h0, 6'b000000, 0, 0);
    step("len4_b1",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("len4_b2",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("len4_b3",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("len4_b4",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("len4_done", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 1);
    step("len4_idle", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);

    // len=0 behaves like len=1.
    step("len0_req",  0, 0, 1, 6'd0, 0, 32'h0, 6'b000000, 0, 0);
    step("len0_b1",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("len0_done", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 1);
    step("len0_idle", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);

    // len=10 aborted by a flush in the 3rd BUSY cycle; no DONE afterwards.
    step("fl_req",   0, 0, 1, 6'd10, 0, 32'h0,  6'b000000, 0, 0);
    step("fl_b1",    0, 0, 0, 6'd0,  0, 32'h0,  6'b001111, 1, 0);
    step("fl_b2",    0, 0, 0, 6'd0,  0, 32'h0,  6'b001111, 1, 0);
    step("fl_b3",    0, 0, 0, 6'd0,  1, 32'h20, 6'b000000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step("fl_after", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);
    end

    // Request together with EX stall in IDLE: both honoured. Request in DONE dropped.
    step("both_req",  0, 1, 1, 6'd1, 0, 32'h0, 6'b001111, 0, 0);
    step("both_b1",   0, 0, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0);
    step("both_done", 0, 0, 1, 6'd3, 0, 32'h0, 6'b000000, 0, 1);
    step("both_idle", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);

    // ID hazard alone for 3 cycles, then ID+EX, then flush overriding ID.
    step("id_1",    1, 0, 0, 6'd0, 0, 32'h0,    6'b000111, 0, 0);
    step("id_2",    1, 0, 0, 6'd0, 0, 32'h0,    6'b000111, 0, 0);
    step("id_3",    1, 0, 0, 6'd0, 0, 32'h0,    6'b000111, 0, 0);
    step("id_ex",   1, 1, 0, 6'd0, 0, 32'h0,    6'b001111, 0, 0);
    step("ex_only", 0, 1, 0, 6'd0, 0, 32'h0,    6'b001111, 0, 0);
    step("id_fl",   1, 0, 0, 6'd0, 1, 32'h1234, 6'b000000, 0, 0);
    step("fl_req_idle", 0, 0, 1, 6'd2, 1, 32'h40, 6'b000000, 0, 0);
    step("quiet",   0, 0, 0, 6'd0, 0, 32'h0,    6'b000000, 0, 0);

    // Asynchronous reset between edges in the middle of a BUSY run.
    step("ar_req", 0, 0, 1, 6'd10, 0, 32'h0, 6'b000000, 0, 0);
    step("ar_b1",  0, 0, 0, 6'd0,  0, 32'h0, 6'b001111, 1, 0);
    step("ar_b2",  1, 0, 0, 6'd0,  0, 32'h0, 6'b001111, 1, 0);
    #1;
    rst = 1'b1;
    #1;
    check32("arst.stall",        32'(stall_o),   32'h0);
    check32("arst.busy",         32'(mc_busy_o), 32'h0);
    check32("arst.done",         32'(mc_done_o), 32'h0);
    check32("arst.stall_cycles", stall_cycles_o, 32'h0);
    rst = 1'b0;
    stallreq_id_i = 1'b0;
    cnt_exp = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step("ar_after", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);
    end

    // Saturation: preload near the top, then stall for 3 cycles.
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    cnt_exp = 32'hFFFF_FFFE;
    step("sat_1", 1, 0, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0);
    step("sat_2", 1, 0, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0);
    step("sat_3", 1, 0, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0);
    step("sat_end", 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0);
    check32("sat.final", stall_cycles_o, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
